thermocouple_spi_responder: RTL and testbench
=============================================

// Module: thermocouple_spi_responder
// PURPOSE
//  SPI responder that models the thermocouple digitiser: SPI mode 0, read-only, 32-bit frames.
//  Periodically "converts" its temperature/fault inputs into a frame snapshot.
//  Serialises the latched snapshot on MISO while CS_n is low, in the format the Thermocouple controller unpacks.
//  Used as the device side in system sims and as a bench stand-in for the real part.
// PARAMETERS
//  CONV_CYCLES  20  clk cycles per conversion; snapshot refreshes at the end of each conversion
//  SYNC_STAGES  2   flops in the CS_n/SCLK synchronisers (>=2)
// PORTS
//  clk               in   1   single system clock, all logic on posedge
//  rst               in   1   synchronous, active-high reset
//  tc_temp_in        in   14  thermocouple temperature, 0.25 C/LSB, two's complement
//  junction_temp_in  in   12  cold-junction temperature, 0.0625 C/LSB, two's complement
//  fault_in          in   3   {SCV, SCG, OC} fault flags
//  spi_cs_n          in   1   chip select, active low, asynchronous to clk
//  spi_sclk          in   1   SPI clock, idle low, asynchronous to clk
//  spi_miso          out  1   serial data, MSB first
//  spi_miso_oe       out  1   1 while the responder drives MISO (CS_n low)
//  conv_busy         out  1   1 while a conversion is in progress
//  frame_done        out  1   1-cycle pulse once bit 0 of a frame has been shifted out
// BEHAVIOUR
//  Reset: spi_miso=0, spi_miso_oe=0, conv_busy=0, frame_done=0; snapshot=0, state=IDLE, conv counter=0.
//  Frame layout:
//    [31:18] = tc;  [17] = 0;  [16] = |fault;  [15:4] = junction;  [3] = 0;  [2:0] = fault.
//  Conversion:
//    - While in IDLE, the counter runs 0..CONV_CYCLES-1; conv_busy=1 throughout.
//    - On the terminal count the snapshot loads the frame from the inputs, the counter wraps to 0, and conversion restarts.
//    - Conversion is frozen outside IDLE. After a frame ends it restarts from 0.
//  Synchronisation:
//    - CS_n and SCLK pass through SYNC_STAGES flops.
//    - Edges are detected on the synchronised signals against a 1-cycle-delayed copy.
//    - The master must hold each SCLK phase >= SYNC_STAGES+2 clk.
//  FSM states: IDLE, SHIFT, TAIL.
//    IDLE -> SHIFT on a synced CS_n fall:
//      - shift reg <= snapshot; bit index <= 31;
//      - spi_oe=1 and spi_miso=bit31 in the same cycle the fall is detected.
//    SHIFT, on a synced SCLK fall:
//      - index 0 -> pulse frame_done, spi_miso=0, go to TAIL;
//      - otherwise decrement the index and present the next bit.
//      - The master samples on SCLK rising edges.
//    TAIL: spi_miso held 0 for any further SCLK edges; no wrap into a second frame.
//    Any state -> IDLE on a synced CS_n rise: spi_miso_oe=0, spi_miso=0, conversion counter restarts from 0.
//  Boundary conditions:
//    - CS_n rising mid-frame aborts the frame; no frame_done pulse.
//    - Conversion terminal count in the same cycle as a CS_n fall: the new snapshot loads first and that frame shifts it.
//    - SCLK edges while CS_n is high are ignored.
//    - rst mid-frame returns to the reset values immediately, regardless of CS_n.
//    - After reset, a CS_n fall before the first conversion completes shifts an all-zero frame.
// CONFIGURATION
//  THERMO_RESP_FAULT_INJECT_EN defined:
//    - adds input fault_inject[2:0];
//    - effective fault = fault_in | fault_inject, feeding bits [2:0] and [16] at snapshot time.
//  Not defined: the port is absent and frames use fault_in only.
// STRUCTURE
//  thermo_pkg (shared with the Thermocouple controller):
//    - frame width 32 and field MSB/LSB localparams (TC, FAULT_ANY, JUNC, FAULT);
//    - resp_state_t enum {IDLE, SHIFT, TAIL};
//    - function build_frame(tc, junc, fault).
//  One sub-module, spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs; instantiated for CS_n and SCLK.
// TESTING
//  1. tc=14'h190, junc=12'h190, fault=0; wait > CONV_CYCLES; 32 SCLK, 5 clk per phase
//     -> master captures 32'h0640_1900, frame_done pulses once.
//  2. Same temps, fault_in=3'b001 -> captured frame 32'h0641_1901.
//  3. CS_n raised after 10 SCLKs -> spi_miso_oe=0 within SYNC_STAGES+1 clk, no frame_done.
//     Next full frame is correct and complete.
//  4. 40 SCLKs in one CS_n window -> bits 31..0 correct, last 8 sampled bits = 0, a single frame_done.
//  5. CS_n fall 2 cycles after reset release -> captured frame 32'h0000_0000.
//     Inputs changed mid-frame do not alter the bits being shifted.
//  6. THERMO_RESP_FAULT_INJECT_EN build, fault_in=0, fault_inject=3'b100 -> frame bits [16]=1 and [2:0]=3'b100.
//     rst asserted mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/thermocouple_spi_responder_pkg.sv
// Shared thermocouple frame definitions: field positions, responder states, frame packing.
package thermo_pkg;

  localparam int unsigned FRAME_W       = 32;
  localparam int unsigned IDX_W         = $clog2(FRAME_W);
  localparam int unsigned TC_MSB        = 31;
  localparam int unsigned TC_LSB        = 18;
  localparam int unsigned FAULT_ANY_BIT = 16;
  localparam int unsigned JUNC_MSB      = 15;
  localparam int unsigned JUNC_LSB      = 4;
  localparam int unsigned FAULT_MSB     = 2;
  localparam int unsigned FAULT_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL
  } resp_state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [13:0] tc,
    input logic [11:0] junc,
    input logic [2:0]  fault
  );
    logic [FRAME_W-1:0] f;
    f                         = '0;
    f[TC_MSB:TC_LSB]          = tc;
    f[FAULT_ANY_BIT]          = |fault;
    f[JUNC_MSB:JUNC_LSB]      = junc;
    f[FAULT_MSB:FAULT_LSB]    = fault;
    return f;
  endfunction

endpackage

// File: rtl/thermocouple_spi_responder_if.sv
// SPI pins between the thermocouple controller (master) and the responder (slave).
interface thermocouple_spi_responder_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_cs_n, output spi_sclk, input spi_miso, input spi_miso_oe);
  modport slave  (input spi_cs_n, input spi_sclk, output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/thermocouple_spi_responder_sync.sv
// Multi-flop synchroniser for an asynchronous input with registered-level edge pulses.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/thermocouple_spi_responder.sv
// Thermocouple digitiser model: periodic snapshot conversion, SPI mode-0 32-bit read-out.
// Build option THERMO_RESP_FAULT_INJECT_EN adds a fault_inject input OR-ed into the fault field.
module thermocouple_spi_responder
  import thermo_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [13:0]                       tc_temp_in,
  input  logic [11:0]                       junction_temp_in,
  input  logic [2:0]                        fault_in,
`ifdef THERMO_RESP_FAULT_INJECT_EN
  input  logic [2:0]                        fault_inject,
`endif
  thermocouple_spi_responder_if.slave       spi,
  output logic                              conv_busy,
  output logic                              frame_done
);

  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  logic cs_level, cs_rise, cs_fall;
  logic sclk_fall, sclk_level_unused, sclk_rise_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .async_in(spi.spi_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .async_in(spi.spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise_unused), .fall(sclk_fall)
  );

  logic [2:0] fault_eff;
`ifdef THERMO_RESP_FAULT_INJECT_EN
  assign fault_eff = fault_in | fault_inject;
`else
  assign fault_eff = fault_in;
`endif

  resp_state_t        state;
  logic [CNT_W-1:0]   conv_cnt;
  logic [FRAME_W-1:0] snapshot;
  logic [FRAME_W-1:0] shift_q;
  logic [IDX_W-1:0]   idx;
  logic               miso_q;
  logic               oe_q;

  logic               conv_term;
  logic [FRAME_W-1:0] frame_now;
  logic [FRAME_W-1:0] snap_next;

  // A terminal count coinciding with the CS_n fall must feed the fresh frame straight to the shifter.
  always_comb begin
    frame_now = build_frame(tc_temp_in, junction_temp_in, fault_eff);
    conv_term = (state == IDLE) && (conv_cnt == CNT_W'(CONV_CYCLES - 1));
    snap_next = conv_term ? frame_now : snapshot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      conv_cnt   <= '0;
      snapshot   <= '0;
      shift_q    <= '0;
      idx        <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      conv_busy  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_rise) begin
        state     <= IDLE;
        conv_cnt  <= '0;
        miso_q    <= 1'b0;
        oe_q      <= 1'b0;
        conv_busy <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            conv_busy <= 1'b1;
            snapshot  <= snap_next;
            conv_cnt  <= conv_term ? '0 : conv_cnt + CNT_W'(1);
            if (cs_fall) begin
              state     <= SHIFT;
              shift_q   <= snap_next;
              idx       <= IDX_W'(FRAME_W - 1);
              miso_q    <= snap_next[FRAME_W-1];
              oe_q      <= 1'b1;
              conv_busy <= 1'b0;
            end
          end
          SHIFT: begin
            if (sclk_fall && !cs_level) begin
              if (idx == '0) begin
                frame_done <= 1'b1;
                miso_q     <= 1'b0;
                state      <= TAIL;
              end else begin
                idx    <= idx - IDX_W'(1);
                miso_q <= shift_q[idx - IDX_W'(1)];
              end
            end
          end
          TAIL: begin
            miso_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;

endmodule

// File: tb/tb_thermocouple_spi_responder.sv
// Directed and randomized SPI read-out checks against a frame-format reference model.
module tb_thermocouple_spi_responder;

  localparam int unsigned CONV_CYCLES = 20;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PHASE       = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] tc_temp_in;
  logic [11:0] junction_temp_in;
  logic [2:0]  fault_in;
`ifdef THERMO_RESP_FAULT_INJECT_EN
  logic [2:0]  fault_inject;
`endif
  logic        conv_busy;
  logic        frame_done;

  thermocouple_spi_responder_if spi_bus ();

  thermocouple_spi_responder #(
    .CONV_CYCLES(CONV_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tc_temp_in       (tc_temp_in),
    .junction_temp_in (junction_temp_in),
    .fault_in         (fault_in),
`ifdef THERMO_RESP_FAULT_INJECT_EN
    .fault_inject     (fault_inject),
`endif
    .spi              (spi_bus.slave),
    .conv_busy        (conv_busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fd_cnt = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: the frame expressed as a weighted sum of its fields.
  function automatic logic [31:0] model_frame(input int tc, input int junc, input int f);
    longint v;
    v = longint'(tc) * 262144 + ((f != 0) ? 65536 : 0) + longint'(junc) * 16 + longint'(f);
    return v[31:0];
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low;
    spi_bus.spi_cs_n = 1'b0;
    cycles(PHASE + 1);
  endtask

  task automatic cs_high;
    spi_bus.spi_cs_n = 1'b1;
    cycles(PHASE + 1);
  endtask

  task automatic clock_bits(input int n, output logic [63:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[62:0], spi_bus.spi_miso};
      spi_bus.spi_sclk = 1'b1;
      cycles(PHASE);
      spi_bus.spi_sclk = 1'b0;
      cycles(PHASE);
    end
  endtask

  task automatic set_inputs(input int tc, input int junc, input int f);
    tc_temp_in       = 14'(tc);
    junction_temp_in = 12'(junc);
    fault_in         = 3'(f);
  endtask

  initial begin
    logic [63:0] cap;
    logic [31:0] exp_frame;
    int          fd0;
    int          tc, junc, f;

    rst = 1'b1;
    spi_bus.spi_cs_n = 1'b1;
    spi_bus.spi_sclk = 1'b0;
    set_inputs(0, 0, 0);
`ifdef THERMO_RESP_FAULT_INJECT_EN
    fault_inject = '0;
`endif
    cycles(3);
    chk("rst_miso", 64'(spi_bus.spi_miso), 64'd0);
    chk("rst_oe", 64'(spi_bus.spi_miso_oe), 64'd0);
    chk("rst_busy", 64'(conv_busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);

    // After reset: CS_n falls before the first conversion completes -> zero frame.
    set_inputs('h1ABC, 'hABC, 3'b101);
    rst = 1'b0;
    cycles(2);
    cs_low();
    chk("t5_oe", 64'(spi_bus.spi_miso_oe), 64'd1);
    chk("t5_busy_frame", 64'(conv_busy), 64'd0);
    fd0 = fd_cnt;
    clock_bits(16, cap);
    set_inputs('h0155, 'h0F0, 3'b010);
    begin
      logic [63:0] cap2;
      clock_bits(16, cap2);
      cap = {cap[47:0], cap2[15:0]};
    end
    chk("t5_zero_frame", {32'd0, cap[31:0]}, 64'd0);
    chk("t5_done", 64'(fd_cnt - fd0), 64'd1);
    cs_high();
    chk("t5_busy_idle", 64'(conv_busy), 64'd1);

    // Directed frames.
    set_inputs('h190, 'h190, 0);
    cycles(CONV_CYCLES + 10);
    cs_low();
    fd0 = fd_cnt;
    clock_bits(32, cap);
    chk("t1_frame", {32'd0, cap[31:0]}, {32'd0, 32'h0640_1900});
    chk("t1_model", {32'd0, cap[31:0]}, {32'd0, model_frame('h190, 'h190, 0)});
    chk("t1_done", 64'(fd_cnt - fd0), 64'd1);
    cs_high();

    set_inputs('h190, 'h190, 1);
    cycles(CONV_CYCLES + 10);
    cs_low();
    clock_bits(32, cap);
    chk("t2_frame", {32'd0, cap[31:0]}, {32'd0, 32'h0641_1901});
    cs_high();

    // Abort after 10 SCLKs.
    cycles(CONV_CYCLES + 10);
    cs_low();
    fd0 = fd_cnt;
    clock_bits(10, cap);
    chk("t3_partial", {54'd0, cap[9:0]}, {54'd0, 10'(32'h0641_1901 >> 22)});
    spi_bus.spi_cs_n = 1'b1;
    cycles(SYNC_STAGES + 1);
    chk("t3_oe_off", 64'(spi_bus.spi_miso_oe), 64'd0);
    chk("t3_miso_off", 64'(spi_bus.spi_miso), 64'd0);
    cycles(PHASE);
    chk("t3_no_done", 64'(fd_cnt - fd0), 64'd0);
    cycles(CONV_CYCLES + 10);
    cs_low();
    fd0 = fd_cnt;
    clock_bits(32, cap);
    chk("t3_next_frame", {32'd0, cap[31:0]}, {32'd0, 32'h0641_1901});
    chk("t3_next_done", 64'(fd_cnt - fd0), 64'd1);
    cs_high();

    // 40 SCLKs in one window: trailing bits are zero, single frame_done.
    set_inputs('h2A5, 'h5A3, 3'b110);
    exp_frame = model_frame('h2A5, 'h5A3, 3'b110);
    cycles(CONV_CYCLES + 10);
    cs_low();
    fd0 = fd_cnt;
    clock_bits(40, cap);
    chk("t4_frame", {32'd0, cap[39:8]}, {32'd0, exp_frame});
    chk("t4_tail", {56'd0, cap[7:0]}, 64'd0);
    chk("t4_done", 64'(fd_cnt - fd0), 64'd1);
    cs_high();

    // Randomized frames; inputs change mid-frame without disturbing the shifted bits.
    for (int n = 0; n < 4; n++) begin
      logic [63:0] hi, lo;
      tc   = int'($urandom_range(0, 16383));
      junc = int'($urandom_range(0, 4095));
      f    = int'($urandom_range(0, 7));
      set_inputs(tc, junc, f);
      exp_frame = model_frame(tc, junc, f);
      cycles(CONV_CYCLES + 10);
      cs_low();
      fd0 = fd_cnt;
      clock_bits(16, hi);
      set_inputs(int'($urandom_range(0, 16383)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)));
      clock_bits(16, lo);
      chk("rand_frame", {32'd0, hi[15:0], lo[15:0]}, {32'd0, exp_frame});
      chk("rand_done", 64'(fd_cnt - fd0), 64'd1);
      cs_high();
    end

`ifdef THERMO_RESP_FAULT_INJECT_EN
    set_inputs('h190, 'h190, 0);
    fault_inject = 3'b100;
    cycles(CONV_CYCLES + 10);
    cs_low();
    clock_bits(32, cap);
    chk("t6_any_fault", 64'(cap[16]), 64'd1);
    chk("t6_fault", 64'(cap[2:0]), 64'd4);
    cs_high();
    fault_inject = '0;
`endif

    // Reset mid-frame returns every output to its reset value on the next cycle.
    cycles(CONV_CYCLES + 10);
    cs_low();
    fd0 = fd_cnt;
    clock_bits(10, cap);
    spi_bus.spi_sclk = 1'b1;
    cycles(1);
    rst = 1'b1;
    cycles(1);
    chk("rstmid_miso", 64'(spi_bus.spi_miso), 64'd0);
    chk("rstmid_oe", 64'(spi_bus.spi_miso_oe), 64'd0);
    chk("rstmid_busy", 64'(conv_busy), 64'd0);
    chk("rstmid_done", 64'(frame_done), 64'd0);
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_cs_n = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(PHASE);
    chk("rstmid_no_done", 64'(fd_cnt - fd0), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
